// File: rtl/debounce_filter_bank_if.sv
// debounce_filter_bank_if
//   Groups the per-channel data signals of debounce_filter_bank.
//   i_Bouncy     raw asynchronous inputs, bit n = channel n
//   o_Debounced  filtered stable levels
//   o_Rise       1-cycle pulse on an accepted 0->1 transition
//   o_Fall       1-cycle pulse on an accepted 1->0 transition
//   o_Long       1-cycle long-press pulse (0 unless DEBOUNCE_LONG_PRESS_EN)
//   master: drives i_Bouncy (board / bench side)
//   slave : the filter bank
interface debounce_filter_bank_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] i_Bouncy;
    logic [NUM_CH-1:0] o_Debounced;
    logic [NUM_CH-1:0] o_Rise;
    logic [NUM_CH-1:0] o_Fall;
    logic [NUM_CH-1:0] o_Long;

    modport master (output i_Bouncy, input o_Debounced, o_Rise, o_Fall, o_Long);
    modport slave  (input i_Bouncy, output o_Debounced, o_Rise, o_Fall, o_Long);
endinterface

// File: rtl/debounce_filter_bank.sv
// debounce_filter_bank
//   NUM_CH independent switch debouncers. Each raw input is resynchronised
//   through SYNC_STAGES flops, then must differ from the current debounced
//   level for DEBOUNCE_LIMIT consecutive cycles before the level flips.
//   Accepted transitions also produce registered 1-cycle rise/fall pulses.
//   Optional long-press detect is compiled in with `define DEBOUNCE_LONG_PRESS_EN.
// Ports:
//   i_Clk    system clock
//   i_Rst_L  asynchronous active-low reset
//   bus      debounce_filter_bank_if.slave (i_Bouncy in; o_Debounced,
//            o_Rise, o_Fall, o_Long out)

// One channel: synchroniser, stability counter, edge pulses, hold counter.
module debounce_lane #(
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter int   SYNC_STAGES    = 2,
    parameter logic INIT_LEVEL     = 1'b0,
    parameter int   LONG_LIMIT     = 25000000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_bouncy,
    output logic o_deb,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);
    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    // Stage 0 is the LSB; the MSB is the resynchronised sample.
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_bouncy};
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == deb_q) begin
            // Any return to the stable level restarts the count.
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_LIMIT - 1)) begin
            deb_d  = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q  <= '0;
            deb_q  <= INIT_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_deb  = deb_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_LIMIT + 1);

    logic [LW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Hold counter saturates at LONG_LIMIT, so the pulse fires once per press;
    // it re-arms only when the debounced level drops back to 0.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!deb_q) begin
            hold_d = '0;
        end else if (hold_q != LW'(LONG_LIMIT)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == LW'(LONG_LIMIT - 1));
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign o_long = long_q;
`else
    assign o_long = 1'b0;
`endif
endmodule

module debounce_filter_bank #(
    parameter int   NUM_CH         = 4,
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter int   SYNC_STAGES    = 2,
    parameter logic INIT_LEVEL     = 1'b0,
    parameter int   LONG_LIMIT     = 25000000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    debounce_filter_bank_if.slave  bus
);
    logic [NUM_CH-1:0] deb, rise, fall, lng;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        debounce_lane #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .SYNC_STAGES    (SYNC_STAGES),
            .INIT_LEVEL     (INIT_LEVEL),
            .LONG_LIMIT     (LONG_LIMIT)
        ) u_lane (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_bouncy (bus.i_Bouncy[g]),
            .o_deb    (deb[g]),
            .o_rise   (rise[g]),
            .o_fall   (fall[g]),
            .o_long   (lng[g])
        );
    end

    assign bus.o_Debounced = deb;
    assign bus.o_Rise      = rise;
    assign bus.o_Fall      = fall;
    assign bus.o_Long      = lng;
endmodule

// File: tb/tb_debounce_filter_bank.sv
// tb_debounce_filter_bank
//   Scoreboarded bench: each stimulus step pushes the edge at which the
//   filter must respond (input change + SYNC_STAGES + DEBOUNCE_LIMIT edges,
//   plus LONG_LIMIT more for the long-press pulse when compiled in). A
//   negedge monitor pops due events and checks every output every cycle.
module tb_debounce_filter_bank;
    localparam int NUM_CH = 4;
    localparam int LIMIT  = 4;
    localparam int SYNC   = 2;
    localparam int LONG   = 10;
    localparam int LAT    = SYNC + LIMIT;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lng;
    } ev_t;

    logic i_Clk;
    logic i_Rst_L;

    debounce_filter_bank_if #(.NUM_CH(NUM_CH)) bus ();

    debounce_filter_bank #(
        .NUM_CH         (NUM_CH),
        .DEBOUNCE_LIMIT (LIMIT),
        .SYNC_STAGES    (SYNC),
        .INIT_LEVEL     (1'b0),
        .LONG_LIMIT     (LONG)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .bus     (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    ev_t        sb[$];
    ev_t        keep[$];
    logic [3:0] exp_deb = 4'b0;

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // Expect a response LAT edges from now (inputs change just after an edge).
    task automatic push(input logic [3:0] rise, input logic [3:0] fall);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.rise = rise;
        e.fall = fall;
        e.lng  = 4'b0;
        sb.push_back(e);
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (rise != 4'b0) begin
            e.cyc  = cyc + LAT + LONG;
            e.rise = 4'b0;
            e.fall = 4'b0;
            e.lng  = rise;
            sb.push_back(e);
        end
`endif
    endtask

    task automatic monitor();
        logic [3:0] r, f, l;
        r = 4'b0;
        f = 4'b0;
        l = 4'b0;
        if (i_Rst_L) begin
            keep.delete();
            foreach (sb[i]) begin
                if (sb[i].cyc == cyc) begin
                    r |= sb[i].rise;
                    f |= sb[i].fall;
                    l |= sb[i].lng;
                end else begin
                    keep.push_back(sb[i]);
                end
            end
            sb = keep;
            exp_deb ^= (r | f);
        end
        chk($sformatf("deb@%0d", cyc),  32'(bus.o_Debounced), 32'(exp_deb));
        chk($sformatf("rise@%0d", cyc), 32'(bus.o_Rise),      32'(r));
        chk($sformatf("fall@%0d", cyc), 32'(bus.o_Fall),      32'(f));
        chk($sformatf("long@%0d", cyc), 32'(bus.o_Long),      32'(l));
    endtask

    always @(negedge i_Clk) monitor();

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    initial begin
        // reset held with all inputs high: outputs must stay 0
        i_Rst_L      = 1'b0;
        bus.i_Bouncy = 4'hF;
        tick(5);
        i_Rst_L      = 1'b1;
        bus.i_Bouncy = 4'h0;
        tick(10);

        // clean press on ch0
        bus.i_Bouncy[0] = 1'b1;
        push(4'b0001, 4'b0000);
        tick(20);

        // bouncing ch1: high, low, then steady high
        bus.i_Bouncy[1] = 1'b1;
        tick(1);
        bus.i_Bouncy[1] = 1'b0;
        tick(1);
        bus.i_Bouncy[1] = 1'b1;
        push(4'b0010, 4'b0000);
        tick(20);

        // 3-cycle glitch on ch2 is rejected
        bus.i_Bouncy[2] = 1'b1;
        tick(3);
        bus.i_Bouncy[2] = 1'b0;
        tick(10);

        // ch2/ch3 together, rise then fall
        bus.i_Bouncy[3:2] = 2'b11;
        push(4'b1100, 4'b0000);
        tick(20);
        bus.i_Bouncy[3:2] = 2'b00;
        push(4'b0000, 4'b1100);
        tick(12);

        // reset in the middle of a ch0 count
        bus.i_Bouncy[0] = 1'b0;
        push(4'b0000, 4'b0001);
        tick(12);
        bus.i_Bouncy[0] = 1'b1;
        tick(3);
        i_Rst_L = 1'b0;
        sb.delete();
        exp_deb = 4'b0;
        #1;
        chk("rst_async_deb",  32'(bus.o_Debounced), 32'h0);
        chk("rst_async_rise", 32'(bus.o_Rise),      32'h0);
        chk("rst_async_fall", 32'(bus.o_Fall),      32'h0);
        tick(3);
        i_Rst_L = 1'b1;
        // ch0 and ch1 are still high and relearn with full latency
        push(4'b0011, 4'b0000);
        tick(20);

        // release, then two separate presses on ch0 (long-press re-arm)
        bus.i_Bouncy[1:0] = 2'b00;
        push(4'b0000, 4'b0011);
        tick(12);
        for (int p = 0; p < 2; p++) begin
            bus.i_Bouncy[0] = 1'b1;
            push(4'b0001, 4'b0000);
            tick(30);
            bus.i_Bouncy[0] = 1'b0;
            push(4'b0000, 4'b0001);
            tick(12);
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
